add_mul_mix_acc_4_bit: RTL and testbench
========================================

ADD_MUL_MIX_ACC_4_BIT -- requirements
Module: add_mul_mix_acc_4_bit

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 4, number of products summed per output block (legal 1..16).
REQ-002 The block SHALL have parameter ACC_W, default 12, accumulator and output width (legal 9..16).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 prod_in  input  8  unsigned 8-bit product, Result[7:0] of the upstream 4-bit add/multiply stage.
REQ-007 prod_valid  input  1  prod_in carries a valid product this cycle.
REQ-008 prod_ready  output  1  block accepts prod_in this cycle.
REQ-009 clear  input  1  synchronous abort of the current block.
REQ-010 acc_out  output  ACC_W  sum of the completed block, registered.
REQ-011 acc_valid  output  1  acc_out and ovf hold a completed block.
REQ-012 acc_ready  input  1  downstream accepts acc_out.
REQ-013 ovf  output  1  completed block saturated; qualified by acc_valid.

Function
REQ-014 A product SHALL be accepted on a rising edge where prod_valid=1 and prod_ready=1; there is no other accept condition.
REQ-015 The FSM SHALL have exactly two states: ACC (prod_ready=1, acc_valid=0) and DONE (prod_ready=0, acc_valid=1).
REQ-016 In ACC, each accepted product SHALL be zero-extended and added to the accumulator, and a term counter SHALL increment by 1.
REQ-017 Any sum exceeding 2^ACC_W-1 SHALL saturate to 2^ACC_W-1 and set a sticky overflow flag for the block; later adds in the same block SHALL leave the accumulator at the saturated value.
REQ-018 On acceptance of the N_TERMS-th product, the next state SHALL be DONE, and acc_out and ovf SHALL present the final sum and flag from the cycle after that accept.
REQ-019 Latency from the last accepted product to acc_valid=1 SHALL be exactly 1 cycle.
REQ-020 In DONE, acc_out, ovf and acc_valid SHALL hold stable until acc_ready=1.
REQ-021 On a DONE cycle with acc_ready=1, the next state SHALL be ACC with accumulator, counter and overflow flag zeroed; prod_ready SHALL be 1 in the following cycle.
REQ-022 There SHALL be no skid buffering: products presented during DONE are not accepted, and prod_valid may stay asserted.
REQ-023 In state ACC, clear=1 SHALL zero the accumulator, counter and flag, and SHALL discard any product presented that cycle; the state stays ACC.
REQ-024 In state DONE, clear=1 SHALL drop the block without a transfer, even if acc_ready=1, and return to ACC with state zeroed.
REQ-025 If N_TERMS=1, every accepted product SHALL produce a block, so a new block completes at most every 2 cycles.
REQ-026 The counter SHALL be wide enough for N_TERMS=16 and SHALL never wrap within a block.

Reset
REQ-027 rst=1 SHALL, on the next edge, force state ACC; accumulator, counter, flag, acc_out and ovf go to 0 and acc_valid goes to 0.
REQ-028 prod_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Priority SHALL be rst > clear > handshakes.
REQ-030 A reset in the middle of a block SHALL discard the partial sum.

Verification
REQ-031 Defaults, products 10, 20, 30, 40 on consecutive cycles, acc_ready=1 -> acc_valid=1 for one cycle after the 4th accept, acc_out=100, ovf=0.
REQ-032 ACC_W=10, N_TERMS=8, eight products of 255 -> acc_out=1023, ovf=1; after the handshake the next block of eight 1s gives acc_out=8, ovf=0.
REQ-033 Defaults, block complete with acc_ready=0 for 5 cycles and prod_valid held high -> prod_ready=0 and acc_out stable throughout; no product lost or double-counted in the next block.
REQ-034 Defaults, 2 products (50, 60) then clear, then 4 products of 1 -> acc_out=4.
REQ-035 Defaults, rst asserted after 3 products, then 4 products of 5 -> acc_out=20; rst asserted during DONE -> acc_valid=0 on the next edge.
REQ-036 N_TERMS=1, prod_valid held high with products 7, 8, 9 -> outputs 7, 8, 9 on alternate cycles with acc_ready=1.

Source files
------------

// File: rtl/add_mul_mix_acc_4_bit.sv
// Block accumulator for the 4-bit add/multiply datapath.
// Sums N_TERMS unsigned 8-bit products into a saturating ACC_W-bit total,
// then presents the total on a valid/ready output port.
// There is no skid buffer, so input and output are never serviced at the same time.

module add_mul_mix_acc_4_bit #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf
);

  // Five bits hold a count of 16, so the counter cannot wrap inside a block.
  localparam int unsigned     CntW    = 5;
  localparam logic [CntW-1:0] LastCnt = CntW'(N_TERMS - 1);
  localparam logic [ACC_W-1:0] AccMax = '1;

  localparam logic StAcc  = 1'b0;
  localparam logic StDone = 1'b1;

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             ovf_out_q, ovf_out_d;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;

  assign prod_ready = (state_q == StAcc);
  // A clear in the same cycle discards the product.
  assign accept     = prod_ready & prod_valid & ~clear;

  // Once the accumulator is saturated, any further non-zero add overflows again.
  // The result therefore stays pinned at the maximum value.
  assign sum     = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod_in};
  assign sum_ovf = sum[ACC_W];
  assign sum_sat = sum_ovf ? AccMax : sum[ACC_W-1:0];

  // Next-state logic for the ACC/DONE handshake FSM and the accumulator datapath.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    acc_out_d = acc_out_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      StAcc: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          acc_d = sum_sat;
          ovf_d = ovf_q | sum_ovf;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d   = StDone;
            acc_out_d = sum_sat;
            ovf_out_d = ovf_q | sum_ovf;
          end
        end
      end
      StDone: begin
        // A clear drops the block even when the consumer is ready.
        if (clear || acc_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = StAcc;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      acc_out_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      acc_out_q <= acc_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign acc_valid = (state_q == StDone);
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_out_q;

endmodule

// File: tb/tb_add_mul_mix_acc_4_bit.sv
// Bench for add_mul_mix_acc_4_bit.
// Three instances cover the default build, a narrow saturating build and a one-term build.

module tb_add_mul_mix_acc_4_bit;

  localparam int WA = 12;
  localparam int WB = 10;
  localparam int WC = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic clear = 1'b0;

  logic [7:0]    pin_a = '0, pin_b = '0, pin_c = '0;
  logic          pv_a = 0, pv_b = 0, pv_c = 0;
  logic          pr_a, pr_b, pr_c;
  logic          ar_a = 0, ar_b = 0, ar_c = 0;
  logic          av_a, av_b, av_c;
  logic          ovf_a, ovf_b, ovf_c;
  logic [WA-1:0] ao_a;
  logic [WB-1:0] ao_b;
  logic [WC-1:0] ao_c;

  add_mul_mix_acc_4_bit #(.N_TERMS(4), .ACC_W(WA)) u_a (
    .clk(clk), .rst(rst), .prod_in(pin_a), .prod_valid(pv_a), .prod_ready(pr_a),
    .clear(clear), .acc_out(ao_a), .acc_valid(av_a), .acc_ready(ar_a), .ovf(ovf_a)
  );
  add_mul_mix_acc_4_bit #(.N_TERMS(8), .ACC_W(WB)) u_b (
    .clk(clk), .rst(rst), .prod_in(pin_b), .prod_valid(pv_b), .prod_ready(pr_b),
    .clear(clear), .acc_out(ao_b), .acc_valid(av_b), .acc_ready(ar_b), .ovf(ovf_b)
  );
  add_mul_mix_acc_4_bit #(.N_TERMS(1), .ACC_W(WC)) u_c (
    .clk(clk), .rst(rst), .prod_in(pin_c), .prod_valid(pv_c), .prod_ready(pr_c),
    .clear(clear), .acc_out(ao_c), .acc_valid(av_c), .acc_ready(ar_c), .ovf(ovf_c)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Scoreboard entries are {ovf, acc_out zero-extended to 16 bits}.
  typedef logic [16:0] ent_t;
  ent_t q_a[$];
  ent_t q_b[$];
  ent_t q_c[$];

  // Bench model of each instance's partial block.
  int   ms[3];
  int   mc[3];
  logic mo[3];
  int   nterm[3] = '{4, 8, 1};
  int   wd[3]    = '{12, 10, 12};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic model_flush(input int id);
    ms[id] = 0;
    mc[id] = 0;
    mo[id] = 1'b0;
    case (id)
      0: q_a.delete();
      1: q_b.delete();
      default: q_c.delete();
    endcase
  endtask

  task automatic model_add(input int id, input int p);
    int   maxv;
    ent_t e;
    maxv = (1 << wd[id]) - 1;
    ms[id] = ms[id] + p;
    if (ms[id] > maxv) begin
      ms[id] = maxv;
      mo[id] = 1'b1;
    end
    mc[id]++;
    if (mc[id] == nterm[id]) begin
      e = {mo[id], 16'(ms[id])};
      case (id)
        0: q_a.push_back(e);
        1: q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
      ms[id] = 0;
      mc[id] = 0;
      mo[id] = 1'b0;
    end
  endtask

  // Output monitors pop one expected entry for each completed transfer.
  ent_t got_a, got_b, got_c, exp_a, exp_b, exp_c;
  int   pops_c = 0;
  int   last_c = 0;

  initial forever begin
    @(negedge clk);
    if (!rst && !clear && av_a && ar_a) begin
      got_a = {ovf_a, 16'(ao_a)};
      n_checks++;
      if (q_a.size() == 0) begin
        $display("FAIL out_a_unexpected: got %h, required no output", got_a);
      end else begin
        exp_a = q_a.pop_front();
        if (got_a !== exp_a) $display("FAIL out_a: got %h, required %h", got_a, exp_a);
        else n_pass++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && !clear && av_b && ar_b) begin
      got_b = {ovf_b, 16'(ao_b)};
      n_checks++;
      if (q_b.size() == 0) begin
        $display("FAIL out_b_unexpected: got %h, required no output", got_b);
      end else begin
        exp_b = q_b.pop_front();
        if (got_b !== exp_b) $display("FAIL out_b: got %h, required %h", got_b, exp_b);
        else n_pass++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && !clear && av_c && ar_c) begin
      got_c = {ovf_c, 16'(ao_c)};
      n_checks++;
      if (q_c.size() == 0) begin
        $display("FAIL out_c_unexpected: got %h, required no output", got_c);
      end else begin
        exp_c = q_c.pop_front();
        if (got_c !== exp_c) $display("FAIL out_c: got %h, required %h", got_c, exp_c);
        else n_pass++;
      end
      if (pops_c > 0) begin
        n_checks++;
        if (cyc - last_c !== 2)
          $display("FAIL out_c_spacing: got %0d cycles, required 2", cyc - last_c);
        else n_pass++;
      end
      pops_c++;
      last_c = cyc;
    end
  end

  task automatic set_in(input int id, input logic v, input logic [7:0] p);
    case (id)
      0: begin pv_a = v; pin_a = p; end
      1: begin pv_b = v; pin_b = p; end
      default: begin pv_c = v; pin_c = p; end
    endcase
  endtask

  // Present one product and hold it until accepted; returns at accept edge + 1.
  task automatic send(input int id, input logic [7:0] p);
    logic ok;
    logic rdy;
    ok = 1'b0;
    set_in(id, 1'b1, p);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = (id == 0) ? pr_a : (id == 1) ? pr_b : pr_c;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    set_in(id, 1'b0, p);
    n_checks++;
    if (!ok) $display("FAIL send_timeout: got no accept for dut %0d, required accept", id);
    else begin
      n_pass++;
      model_add(id, int'(p));
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) break;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0)
      $display("FAIL drain: got %0d pending, required 0", q_a.size() + q_b.size() + q_c.size());
    else n_pass++;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int id = 0; id < 3; id++) model_flush(id);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    pv_a = 1'b1;
    pin_a = 8'd200;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (av_a !== 1'b0) $display("FAIL rst_av_a: got %b, required 0", av_a); else n_pass++;
    n_checks++;
    if (ao_a !== '0) $display("FAIL rst_ao_a: got %h, required 0", ao_a); else n_pass++;
    n_checks++;
    if (ovf_a !== 1'b0) $display("FAIL rst_ovf_a: got %b, required 0", ovf_a); else n_pass++;
    n_checks++;
    if (ao_b !== '0) $display("FAIL rst_ao_b: got %h, required 0", ao_b); else n_pass++;
    n_checks++;
    if (av_c !== 1'b0) $display("FAIL rst_av_c: got %b, required 0", av_c); else n_pass++;
    pv_a = 1'b0;
    rst  = 1'b0;
    for (int id = 0; id < 3; id++) model_flush(id);
    n_checks++;
    if (pr_a !== 1'b1) $display("FAIL rst_pr_a: got %b, required 1", pr_a); else n_pass++;
    n_checks++;
    if (pr_b !== 1'b1) $display("FAIL rst_pr_b: got %b, required 1", pr_b); else n_pass++;
  endtask

  task automatic test_back_to_back();
    ar_a = 1'b1;
    send(0, 8'd10);
    send(0, 8'd20);
    send(0, 8'd30);
    send(0, 8'd40);
    n_checks++;
    if (av_a !== 1'b1) $display("FAIL b2b_av_hi: got %b, required 1", av_a); else n_pass++;
    n_checks++;
    if (ao_a !== 12'd100) $display("FAIL b2b_ao: got %0d, required 100", ao_a); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (av_a !== 1'b0) $display("FAIL b2b_av_lo: got %b, required 0", av_a); else n_pass++;
    n_checks++;
    if (pr_a !== 1'b1) $display("FAIL b2b_pr: got %b, required 1", pr_a); else n_pass++;
    wait_drain();
  endtask

  task automatic test_hold();
    ar_a = 1'b0;
    send(0, 8'd1);
    send(0, 8'd2);
    send(0, 8'd3);
    send(0, 8'd4);
    pv_a  = 1'b1;
    pin_a = 8'd3;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (pr_a !== 1'b0) $display("FAIL hold_pr[%0d]: got %b, required 0", i, pr_a);
      else n_pass++;
      n_checks++;
      if (av_a !== 1'b1 || ao_a !== 12'd10)
        $display("FAIL hold_out[%0d]: got %b/%0d, required 1/10", i, av_a, ao_a);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    ar_a = 1'b1;
    send(0, 8'd3);
    send(0, 8'd3);
    send(0, 8'd3);
    send(0, 8'd3);
    wait_drain();
  endtask

  task automatic test_clear();
    ar_a = 1'b1;
    send(0, 8'd50);
    send(0, 8'd60);
    pv_a  = 1'b1;
    pin_a = 8'd99;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    pv_a  = 1'b0;
    model_flush(0);
    n_checks++;
    if (pr_a !== 1'b1 || av_a !== 1'b0)
      $display("FAIL clr_acc: got pr=%b av=%b, required pr=1 av=0", pr_a, av_a);
    else n_pass++;
    repeat (4) send(0, 8'd1);
    wait_drain();
    // Clear during DONE drops the block even with acc_ready high.
    repeat (4) send(0, 8'd7);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_flush(0);
    n_checks++;
    if (av_a !== 1'b0 || pr_a !== 1'b1)
      $display("FAIL clr_done: got av=%b pr=%b, required av=0 pr=1", av_a, pr_a);
    else n_pass++;
    repeat (4) send(0, 8'd2);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    ar_a = 1'b1;
    send(0, 8'd9);
    send(0, 8'd9);
    send(0, 8'd9);
    pulse_rst();
    repeat (4) send(0, 8'd5);
    wait_drain();
    ar_a = 1'b0;
    repeat (4) send(0, 8'd1);
    n_checks++;
    if (av_a !== 1'b1) $display("FAIL rstd_av_hi: got %b, required 1", av_a); else n_pass++;
    pulse_rst();
    n_checks++;
    if (av_a !== 1'b0 || ao_a !== '0 || ovf_a !== 1'b0)
      $display("FAIL rstd_out: got av=%b ao=%0d ovf=%b, required 0/0/0", av_a, ao_a, ovf_a);
    else n_pass++;
    ar_a = 1'b1;
  endtask

  task automatic test_saturate();
    ar_b = 1'b1;
    repeat (8) send(1, 8'd255);
    repeat (8) send(1, 8'd1);
    wait_drain();
  endtask

  task automatic test_n1();
    ar_c = 1'b1;
    send(2, 8'd7);
    send(2, 8'd8);
    send(2, 8'd9);
    wait_drain();
    n_checks++;
    if (pops_c !== 3) $display("FAIL n1_count: got %0d, required 3", pops_c); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_clear();
    test_reset_mid();
    test_saturate();
    test_n1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
